// File: rtl/pwm_pkg.sv
// Shared types and encodings for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } pwm_state_e;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: compares the shared counter against this channel's duty
// and registers the result.
module pwm_cmp_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm
);

    logic pwm_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_reg <= 1'b0;
        end else begin
            pwm_reg <= run && (cnt < duty);
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM generator: one shared edge/center-aligned period counter,
// per-channel duty comparators, and double-buffered period/duty/mode config.
module pwm_gen_mc
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int N_CH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CNT_W-1:0]      cfg_period,
    input  logic [N_CH*CNT_W-1:0] cfg_duty,
    input  logic                  cfg_center,
    output logic [N_CH-1:0]       pwm_out,
    output logic                  period_start
);

    pwm_state_e             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   boundary;

    logic [CNT_W-1:0]       period_act_reg, period_pend_reg;
    logic [N_CH*CNT_W-1:0]  duty_act_reg, duty_pend_reg;
    logic                   mode_act_reg, mode_pend_reg;
    logic                   pend_flag_reg;

    logic                   accept;
    logic                   apply;
    logic                   run;
    logic                   period_start_next;
    logic                   period_start_reg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; boundary marks the cycle that loads cnt=0 for a new period
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        boundary   = 1'b0;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = UP;
                    cnt_next   = '0;
                    boundary   = 1'b1;
                end
                UP: begin
                    if (cnt_reg >= period_act_reg) begin
                        // P<=1 in center mode has no DOWN leg: period is 0..P only
                        if (mode_act_reg == MODE_CENTER && period_act_reg > CNT_W'(1)) begin
                            state_next = DOWN;
                            cnt_next   = period_act_reg - CNT_W'(1);
                        end else begin
                            state_next = UP;
                            cnt_next   = '0;
                            boundary   = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next = UP;
                        cnt_next   = '0;
                        boundary   = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        run               = en && (state_reg != IDLE);
        period_start_next = en && (state_reg == UP) && (cnt_reg == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start_reg <= 1'b0;
        end else begin
            period_start_reg <= period_start_next;
        end
    end

    assign period_start = period_start_reg;

    // Config shadowing: accept and apply are mutually exclusive via pend_flag_reg
    assign cfg_ready = !pend_flag_reg;
    assign accept    = cfg_valid && cfg_ready;
    assign apply     = pend_flag_reg && (boundary || !en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_pend_reg <= '0;
            duty_pend_reg   <= '0;
            mode_pend_reg   <= MODE_EDGE;
            pend_flag_reg   <= 1'b0;
        end else if (accept) begin
            period_pend_reg <= cfg_period;
            duty_pend_reg   <= cfg_duty;
            mode_pend_reg   <= cfg_center;
            pend_flag_reg   <= 1'b1;
        end else if (apply) begin
            pend_flag_reg   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act_reg <= '0;
            duty_act_reg   <= '0;
            mode_act_reg   <= MODE_EDGE;
        end else if (apply) begin
            period_act_reg <= period_pend_reg;
            duty_act_reg   <= duty_pend_reg;
            mode_act_reg   <= mode_pend_reg;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pwm_cmp_ch #(
            .CNT_W(CNT_W)
        ) u_cmp (
            .clk  (clk),
            .rst_n(rst_n),
            .run  (run),
            .cnt  (cnt_reg),
            .duty (duty_act_reg[gi*CNT_W +: CNT_W]),
            .pwm  (pwm_out[gi])
        );
    end

endmodule

// File: tb/tb_pwm_gen_mc.sv
// Randomized and directed bench for pwm_gen_mc against a phase-based period model.
module tb_pwm_gen_mc;

    localparam int CNT_W = 16;
    localparam int N_CH  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [CNT_W-1:0]      cfg_period;
    logic [N_CH*CNT_W-1:0] cfg_duty;
    logic                  cfg_center;
    logic [N_CH-1:0]       pwm_out;
    logic                  period_start;

    pwm_gen_mc #(
        .CNT_W(CNT_W),
        .N_CH (N_CH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_center  (cfg_center),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: the period is a phase index k in [0, L); the counter value is a
    // function of k, the mode and P. Config applies only when k restarts.
    int              m_P, m_mode, p_P, p_mode;
    int              m_D [N_CH];
    int              p_D [N_CH];
    bit              m_pend, m_run, m_acc;
    int              m_k;
    logic [N_CH-1:0] m_pwm;
    bit              m_ps;

    function automatic int m_len();
        if (m_mode != 0) return (m_P == 0) ? 1 : 2 * m_P;
        return m_P + 1;
    endfunction

    function automatic int m_cnt();
        if (m_mode != 0 && m_k > m_P) return 2 * m_P - m_k;
        return m_k;
    endfunction

    task automatic model_reset();
        m_P = 0; m_mode = 0; p_P = 0; p_mode = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_D[i] = 0;
            p_D[i] = 0;
        end
        m_pend = 0; m_run = 0; m_acc = 0; m_k = 0; m_pwm = '0; m_ps = 0;
    endtask

    task automatic tick();
        bit              acc, bnd, app, run_n;
        int              k_n, c;
        logic [N_CH-1:0] pn;
        acc = cfg_valid && !m_pend;
        c   = m_cnt();
        for (int i = 0; i < N_CH; i++) pn[i] = en && m_run && (c < m_D[i]);
        m_ps = en && m_run && (m_k == 0);
        bnd = 0;
        if (!en) begin
            run_n = 0; k_n = 0;
        end else if (!m_run) begin
            run_n = 1; k_n = 0; bnd = 1;
        end else begin
            run_n = 1; k_n = (m_k + 1) % m_len(); bnd = (k_n == 0);
        end
        app = m_pend && (bnd || !en);
        if (app) begin
            m_P = p_P; m_mode = p_mode;
            for (int i = 0; i < N_CH; i++) m_D[i] = p_D[i];
        end
        if (acc) begin
            p_P = int'(cfg_period); p_mode = int'(cfg_center);
            for (int i = 0; i < N_CH; i++) p_D[i] = int'(cfg_duty[i*CNT_W +: CNT_W]);
            m_pend = 1;
            $display("cfg accepted: P=%0d center=%0d D={%0d,%0d,%0d,%0d} t=%0t",
                     p_P, p_mode, p_D[0], p_D[1], p_D[2], p_D[3], $time);
        end else if (app) begin
            m_pend = 0;
        end
        m_run = run_n; m_k = k_n; m_pwm = pn; m_acc = acc;
        @(posedge clk);
        #1;
        check_eq("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check_eq("period_start", 32'(period_start), 32'(m_ps));
        check_eq("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(input int p, input int center, input int d0, input int d1,
                           input int d2, input int d3);
        cfg_period = CNT_W'(p);
        cfg_center = center[0];
        cfg_duty   = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    endtask

    task automatic offer(input int p, input int center, input int d0, input int d1,
                         input int d2, input int d3);
        int n;
        set_cfg(p, center, d0, d1, d2, d3);
        cfg_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 200);
        cfg_valid = 1'b0;
        check_eq("offer_accepted", 32'(m_acc), 32'd1);
    endtask

    task automatic wait_phase(input int k);
        int n;
        n = 0;
        while (m_k != k && n < 200) begin
            tick();
            n++;
        end
        check_eq("phase_reached", 32'(m_k), 32'(k));
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        #12;
        check_eq("rst_pwm_out", 32'(pwm_out), 32'd0);
        check_eq("rst_period_start", 32'(period_start), 32'd0);
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;

        // Edge mode, P=9, loaded while disabled, then run
        offer(9, 0, 3, 0, 10, 5);
        ticks(2);
        en = 1'b1;
        ticks(32);

        // Reconfigure mid-period: old period completes first
        wait_phase(3);
        offer(4, 0, 2, 0, 0, 0);
        ticks(22);

        // Offer lands on the wrap cycle (cnt=P): applies one period later
        wait_phase(4);
        offer(9, 0, 3, 1, 2, 9);
        ticks(24);

        // en dropped at cnt=6 for 3 cycles
        wait_phase(6);
        en = 1'b0;
        ticks(3);
        en = 1'b1;
        ticks(24);

        // Center mode, then asynchronous reset in the DOWN leg
        offer(4, 1, 2, 4, 5, 1);
        ticks(30);
        wait_phase(6);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_pwm_out", 32'(pwm_out), 32'd0);
        check_eq("arst_period_start", 32'(period_start), 32'd0);
        check_eq("arst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        ticks(20);

        // Randomized traffic
        for (int cyc = 0; cyc < 500; cyc++) begin
            if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 4) != 0);
            if (!cfg_valid && $urandom_range(0, 9) == 0) begin
                int p;
                int d [N_CH];
                p = $urandom_range(0, 12);
                for (int i = 0; i < N_CH; i++)
                    d[i] = ($urandom_range(0, 7) == 0) ? 65535 : $urandom_range(0, p + 2);
                set_cfg(p, $urandom_range(0, 1), d[0], d[1], d[2], d[3]);
                cfg_valid = 1'b1;
            end
            tick();
            if (m_acc) cfg_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_gen_mc.md
Name: pwm_gen_mc

Overview:
- Multi-channel PWM generator. N_CH outputs share one period counter; each channel has its own duty.
- Supports edge-aligned (sawtooth) and center-aligned (triangle) counting.
- Period, duty and mode are double-buffered: new values are accepted via a valid/ready handshake and applied only at a period boundary, so no glitched or truncated pulses.
- Sits between a register/config block and motor/LED driver pins.

Parameters:
- CNT_W, 16, counter/period/duty width in bits
- N_CH, 4, number of PWM channels (1..16)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run enable; low = counter held, outputs low
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  high when no update is pending
- cfg_period  in  CNT_W  period value P
- cfg_duty  in  N_CH*CNT_W  channel i duty D_i at bits [i*CNT_W +: CNT_W]
- cfg_center  in  1  0 = edge-aligned, 1 = center-aligned
- pwm_out  out  N_CH  registered PWM outputs
- period_start  out  1  one-cycle pulse, registered, at the start of each period

Behaviour:
Reset values:
- cnt=0, dir=UP, active P=0, all active D=0, active mode=edge.
- pending_flag=0, cfg_ready=1, pwm_out=0, period_start=0.

Config handshake:
- Transfer occurs when cfg_valid && cfg_ready. Values are captured into pending registers and pending_flag is set; cfg_ready drops the next cycle.
- Pending values are copied to the active registers at the next boundary, i.e. the cycle in which cnt is loaded with 0 for a new period. pending_flag then clears and cfg_ready rises the following cycle.
- If en=0, the pending-to-active copy occurs on the cycle after capture.
- Offers made while cfg_ready=0 are ignored; the upstream block holds cfg_valid.

Counter state machine (states IDLE, UP, DOWN):
- IDLE, entered when en=0:
  - cnt=0, pwm_out=0, period_start=0.
  - en rising: go to UP with cnt=0. This counts as a boundary, so pending config is applied.
- Edge mode: UP only. cnt goes 0..P, then wraps to 0 (boundary). Period = P+1 cycles.
- Center mode:
  - UP: cnt 0..P. At cnt==P, go to DOWN with cnt=P-1.
  - DOWN: cnt P-1..1. At cnt==1, go to UP with cnt=0 (boundary).
  - Period = 2P cycles.
  - P=0 in center mode: cnt stays 0, every cycle is a boundary.
- Mode change takes effect only at a boundary, from the UP state with cnt=0.

Outputs (one-cycle latency, registered):
- pwm_out[i] <= (cnt < D_i), using the active config.
- D_i=0: constant low. D_i > P (edge mode) or D_i > P (center mode): constant high.
- Edge-mode high time = min(D_i, P+1) cycles per period. Center-mode high time = 2*D_i - 1 cycles for 1 <= D_i <= P, centered on cnt=0.
- period_start <= 1 when cnt==0 in UP state and en=1, else 0.

Boundary conditions:
- en dropped mid-period: next cycle cnt=0, IDLE, pwm_out=0. Pending config is kept and applied on the en-low rule above.
- cfg accept and boundary in the same cycle: the new values go to pending and apply at the following boundary, not the current one.
- Arithmetic: all comparisons unsigned, CNT_W bits. Counter never exceeds P; P = 2^CNT_W - 1 is legal.
- Asynchronous reset mid-operation: every register returns to its reset value immediately.

Decomposition:
- Package pwm_pkg:
  - state enum {IDLE, UP, DOWN}
  - localparam for the mode encoding (MODE_EDGE=0, MODE_CENTER=1)
- One sub-module, pwm_cmp_ch: per-channel duty comparator plus output register, instantiated N_CH times with a generate loop.
- Counter, FSM and shadow registers stay in the top module.

Test Plan:
- Edge mode, P=9, D0=3, D1=0, D2=10, D3=5, en=1 -> period 10 cycles; ch0 high 3, ch1 always low, ch2 always high, ch3 high 5; period_start every 10 cycles.
- Center mode, P=4, D0=2 -> period 8 cycles; ch0 high 3 consecutive cycles centered on cnt=0; period_start every 8 cycles.
- Edge P=9 running, new cfg P=4, D0=2 offered at cnt=3 -> cfg_ready low until the boundary; old waveform finishes its 10 cycles, then 5-cycle periods with 2-cycle highs; cfg_ready high the cycle after apply.
- Config accepted on the same cycle as wrap (cnt=P) -> applied one period later, not immediately; no short pulse on any channel.
- en dropped at cnt=6, held 3 cycles, re-raised -> pwm_out=0 the cycle after the drop; restart at cnt=0 with a period_start pulse; full-length first period.
- rst_n asserted mid-DOWN phase in center mode -> all outputs 0, cfg_ready=1 asynchronously; after release with en=1 and no new cfg, P=0 so pwm_out stays 0.
